// File: rtl/pong_game_engine_if.sv
// pong_game_engine_if: bundles the video stream, player controls and game outputs of the Pong engine.
// Latency: none, wires only.
// Backpressure: none; the video stream is free-running, one pixel per clock.
// Signals: nextX/nextY/blank_n/hSync_n/vSync_n from the timing controller, start and paddle levels,
//          registered red/green/blue, delayed blankOut_n/hSyncOut_n/vSyncOut_n, scoreL/scoreR.
// master = video source / player side, slave = the game engine.
interface pong_game_engine_if;
    logic [10:0] nextX;
    logic [9:0]  nextY;
    logic        blank_n;
    logic        hSync_n;
    logic        vSync_n;
    logic        start;
    logic        lUp;
    logic        lDown;
    logic        rUp;
    logic        rDown;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        blankOut_n;
    logic        hSyncOut_n;
    logic        vSyncOut_n;
    logic [3:0]  scoreL;
    logic [3:0]  scoreR;

    modport master (
        output nextX, nextY, blank_n, hSync_n, vSync_n, start, lUp, lDown, rUp, rDown,
        input  red, green, blue, blankOut_n, hSyncOut_n, vSyncOut_n, scoreL, scoreR
    );

    modport slave (
        input  nextX, nextY, blank_n, hSync_n, vSync_n, start, lUp, lDown, rUp, rDown,
        output red, green, blue, blankOut_n, hSyncOut_n, vSyncOut_n, scoreL, scoreR
    );
endinterface

// File: rtl/pong_game_engine.sv
// pong_game_engine: Pong game state (ball, paddles, scores, serve/play/point FSM) plus pixel renderer.
// Latency: RGB and delayed blank/syncs are registered, exactly 1 pixel clock behind the coordinates.
// Backpressure: none; one pixel per clock, game state advances once per frame on the internal tick.
// Ports: Clock, Reset_n (async, active low); io (slave modport of pong_game_engine_if) carries the
//        pixel coordinates, blank/syncs, start and paddle levels in; RGB, delayed syncs, scores out.
// Build option: define PONG_SPEEDUP_EN so every paddle hit raises ball speed by 1 up to MAX_SPEED.
module pong_game_engine #(
    parameter int XRES         = 800,
    parameter int YRES         = 600,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int MAX_SPEED    = 6,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_X     = 16,
    parameter int PADDLE_SPEED = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic              Clock,
    input  logic              Reset_n,
    pong_game_engine_if.slave io
);
    // Speed register is sized for the larger of the start speed and the ceiling.
    localparam int SPEED_TOP = (MAX_SPEED > BALL_SPEED) ? MAX_SPEED : BALL_SPEED;
    localparam int SPW       = $clog2(SPEED_TOP + 1);
    localparam int SCW       = $clog2(SERVE_FRAMES + 1);

    // All position arithmetic is signed 12-bit so "pos - speed" near 0 cannot wrap.
    typedef logic signed [11:0] s12_t;
    localparam s12_t ZERO       = '0;
    localparam s12_t BALL_X0    = s12_t'((XRES - BALL_SIZE) / 2);
    localparam s12_t BALL_Y0    = s12_t'((YRES - BALL_SIZE) / 2);
    localparam s12_t BALL_X_MAX = s12_t'(XRES - BALL_SIZE);
    localparam s12_t BALL_Y_MAX = s12_t'(YRES - BALL_SIZE);
    localparam s12_t PAD_Y0     = s12_t'((YRES - PADDLE_H) / 2);
    localparam s12_t PAD_MAX    = s12_t'(YRES - PADDLE_H);
    localparam s12_t L_X        = s12_t'(PADDLE_X);
    localparam s12_t L_FACE     = s12_t'(PADDLE_X + PADDLE_W);
    localparam s12_t R_X        = s12_t'(XRES - PADDLE_X - PADDLE_W);
    localparam s12_t S_BS       = s12_t'(BALL_SIZE);
    localparam s12_t S_PW       = s12_t'(PADDLE_W);
    localparam s12_t S_PH       = s12_t'(PADDLE_H);
    localparam s12_t S_PSPD     = s12_t'(PADDLE_SPEED);

    typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_GAMEOVER} state_t;

    state_t           state_q, state_d;
    logic [10:0]      ball_x_q, ball_x_d;
    logic [9:0]       ball_y_q, ball_y_d;
    logic [9:0]       pad_l_q, pad_l_d;
    logic [9:0]       pad_r_q, pad_r_d;
    logic             dir_x_q, dir_x_d;     // 1 = moving right (+X)
    logic             dir_y_q, dir_y_d;     // 1 = moving down (+Y)
    logic             point_r_q, point_r_d; // pending point belongs to the right player
    logic [SPW-1:0]   speed_q, speed_d;
    logic [3:0]       score_l_q, score_l_d;
    logic [3:0]       score_r_q, score_r_d;
    logic [SCW-1:0]   serve_cnt_q, serve_cnt_d;
    logic [3:0]       score_nx;
    logic             tick_q;
    logic             lit_q;
    logic             blank_q, hs_q, vs_q;

    s12_t bx, by, pl, pr, step, cand_x, cand_y, px, py;
    logic ov_l, ov_r, hit_l, hit_r;
    logic in_ball, in_lpad, in_rpad;

    function automatic logic [9:0] pad_step(input logic [9:0] p, input logic up, input logic dn);
        s12_t c;
        c = s12_t'({2'b00, p});
        if (up && !dn) begin
            c = c - S_PSPD;
        end else if (dn && !up) begin
            c = c + S_PSPD;
        end
        if (c < ZERO) begin
            c = ZERO;
        end else if (c > PAD_MAX) begin
            c = PAD_MAX;
        end
        return c[9:0];
    endfunction

    assign bx     = s12_t'({1'b0, ball_x_q});
    assign by     = s12_t'({2'b00, ball_y_q});
    assign pl     = s12_t'({2'b00, pad_l_q});
    assign pr     = s12_t'({2'b00, pad_r_q});
    assign step   = s12_t'(speed_q);
    assign cand_x = dir_x_q ? bx + step : bx - step;
    assign cand_y = dir_y_q ? by + step : by - step;

    // Hit tests use the ball row and paddle rows from before this tick's update.
    assign ov_l  = (by < pl + S_PH) && (pl < by + S_BS);
    assign ov_r  = (by < pr + S_PH) && (pr < by + S_BS);
    // "was clear" terms stop a ball already behind a paddle face from being pulled back out.
    assign hit_l = !dir_x_q && (cand_x <= L_FACE) && (bx >= L_FACE) && ov_l;
    assign hit_r = dir_x_q && (cand_x + S_BS >= R_X) && (bx + S_BS <= R_X) && ov_r;

    // Renderer: ball and both paddles are white, so ball priority needs no separate colour mux.
    assign px      = s12_t'({1'b0, io.nextX});
    assign py      = s12_t'({2'b00, io.nextY});
    assign in_ball = (px >= bx) && (px < bx + S_BS) && (py >= by) && (py < by + S_BS);
    assign in_lpad = (px >= L_X) && (px < L_X + S_PW) && (py >= pl) && (py < pl + S_PH);
    assign in_rpad = (px >= R_X) && (px < R_X + S_PW) && (py >= pr) && (py < pr + S_PH);

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        pad_l_d     = pad_l_q;
        pad_r_d     = pad_r_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        point_r_d   = point_r_q;
        speed_d     = speed_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_cnt_d = serve_cnt_q;
        score_nx    = point_r_q ? score_r_q + 4'd1 : score_l_q + 4'd1;

        if (tick_q) begin
            if (state_q != S_IDLE && state_q != S_GAMEOVER) begin
                pad_l_d = pad_step(pad_l_q, io.lUp, io.lDown);
                pad_r_d = pad_step(pad_r_q, io.rUp, io.rDown);
            end

            unique case (state_q)
                S_IDLE: begin
                    if (io.start) begin
                        state_d     = S_SERVE;
                        serve_cnt_d = '0;
                    end
                end
                S_SERVE: begin
                    if (serve_cnt_q == SCW'(SERVE_FRAMES - 1)) begin
                        state_d     = S_PLAY;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + SCW'(1);
                    end
                end
                S_PLAY: begin
                    if (cand_y <= ZERO) begin
                        ball_y_d = '0;
                        dir_y_d  = 1'b1;
                    end else if (cand_y >= BALL_Y_MAX) begin
                        ball_y_d = BALL_Y_MAX[9:0];
                        dir_y_d  = 1'b0;
                    end else begin
                        ball_y_d = cand_y[9:0];
                    end
                    // Paddle hits win over misses; X holds on a miss until POINT recentres.
                    if (hit_l || hit_r) begin
                        ball_x_d = hit_l ? L_FACE[10:0] : (R_X[10:0] - BALL_SIZE[10:0]);
                        dir_x_d  = hit_l;
`ifdef PONG_SPEEDUP_EN
                        if (speed_q < SPW'(MAX_SPEED)) begin
                            speed_d = speed_q + SPW'(1);
                        end
`endif
                    end else if (cand_x <= ZERO) begin
                        state_d   = S_POINT;
                        point_r_d = 1'b1;
                    end else if (cand_x >= BALL_X_MAX) begin
                        state_d   = S_POINT;
                        point_r_d = 1'b0;
                    end else begin
                        ball_x_d = cand_x[10:0];
                    end
                end
                S_POINT: begin
                    if (point_r_q) begin
                        score_r_d = score_nx;
                    end else begin
                        score_l_d = score_nx;
                    end
                    speed_d = SPW'(BALL_SPEED);
                    if (score_nx == 4'(WIN_SCORE)) begin
                        state_d = S_GAMEOVER;
                    end else begin
                        ball_x_d    = BALL_X0[10:0];
                        ball_y_d    = BALL_Y0[9:0];
                        dir_x_d     = !point_r_q;   // serve toward the player who conceded
                        dir_y_d     = 1'b1;
                        serve_cnt_d = '0;
                        state_d     = S_SERVE;
                    end
                end
                S_GAMEOVER: begin
                    if (io.start) begin
                        score_l_d   = '0;
                        score_r_d   = '0;
                        ball_x_d    = BALL_X0[10:0];
                        ball_y_d    = BALL_Y0[9:0];
                        dir_y_d     = 1'b1;
                        speed_d     = SPW'(BALL_SPEED);
                        serve_cnt_d = '0;
                        state_d     = S_SERVE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            ball_x_q    <= BALL_X0[10:0];
            ball_y_q    <= BALL_Y0[9:0];
            pad_l_q     <= PAD_Y0[9:0];
            pad_r_q     <= PAD_Y0[9:0];
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            point_r_q   <= 1'b0;
            speed_q     <= SPW'(BALL_SPEED);
            score_l_q   <= '0;
            score_r_q   <= '0;
            serve_cnt_q <= '0;
            tick_q      <= 1'b0;
            lit_q       <= 1'b0;
            blank_q     <= 1'b1;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            pad_l_q     <= pad_l_d;
            pad_r_q     <= pad_r_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            point_r_q   <= point_r_d;
            speed_q     <= speed_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            serve_cnt_q <= serve_cnt_d;
            // Tick fires the cycle after the last visible pixel of the frame.
            tick_q      <= io.blank_n && (io.nextX == 11'(XRES - 1)) && (io.nextY == 10'(YRES - 1));
            lit_q       <= io.blank_n && (in_ball || in_lpad || in_rpad);
            blank_q     <= io.blank_n;
            hs_q        <= io.hSync_n;
            vs_q        <= io.vSync_n;
        end
    end

    assign io.red        = {8{lit_q}};
    assign io.green      = {8{lit_q}};
    assign io.blue       = {8{lit_q}};
    assign io.blankOut_n = blank_q;
    assign io.hSyncOut_n = hs_q;
    assign io.vSyncOut_n = vs_q;
    assign io.scoreL     = score_l_q;
    assign io.scoreR     = score_r_q;
endmodule

// File: tb/tb_pong_game_engine.sv
module tb_pong_game_engine;
    localparam int XRES = 800, YRES = 600, BS = 8, PW = 8, PH = 64;
    localparam int PXL = 16, PXR = XRES - 16 - 8, PSPD = 4, WIN = 9, SERVE = 60;
    localparam int SPD0 = 2, SPDMAX = 6;
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

    logic Clock = 1'b0;
    logic Reset_n = 1'b0;
    pong_game_engine_if io();

    pong_game_engine dut (.Clock(Clock), .Reset_n(Reset_n), .io(io));

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    // Reference game: plain integers, direction as +1/-1.
    int m_st, m_bx, m_by, m_dx, m_dy, m_spd, m_pl, m_pr, m_sl, m_sr, m_scnt, m_ptr;

    typedef struct {
        int x;
        int y;
        bit bl;
        bit hs;
        bit vs;
        bit lit;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_bx = (XRES - BS) / 2; m_by = (YRES - BS) / 2;
        m_dx = 1; m_dy = 1; m_spd = SPD0; m_pl = (YRES - PH) / 2; m_pr = (YRES - PH) / 2;
        m_sl = 0; m_sr = 0; m_scnt = 0; m_ptr = 0;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int pmove(input bit up, input bit dn);
        if (up && !dn) return -PSPD;
        if (dn && !up) return PSPD;
        return 0;
    endfunction

    function automatic bit overlap(input int y, input int p);
        return (y < p + PH) && (p < y + BS);
    endfunction

    function automatic bit lit_at(input int x, input int y);
        bit b, l, r;
        b = (x >= m_bx) && (x < m_bx + BS) && (y >= m_by) && (y < m_by + BS);
        l = (x >= PXL) && (x < PXL + PW) && (y >= m_pl) && (y < m_pl + PH);
        r = (x >= PXR) && (x < PXR + PW) && (y >= m_pr) && (y < m_pr + PH);
        return b || l || r;
    endfunction

    task automatic bump();
`ifdef PONG_SPEEDUP_EN
        m_spd = (m_spd + 1 > SPDMAX) ? SPDMAX : m_spd + 1;
`endif
    endtask

    task automatic model_tick(input bit st, input bit lu, input bit ld, input bit ru, input bit rd);
        int npl, npr, cx, cy, oy;
        npl = m_pl; npr = m_pr;
        if (m_st != M_IDLE && m_st != M_OVER) begin
            npl = clampi(m_pl + pmove(lu, ld), 0, YRES - PH);
            npr = clampi(m_pr + pmove(ru, rd), 0, YRES - PH);
        end
        case (m_st)
            M_IDLE: if (st) begin m_st = M_SERVE; m_scnt = 0; end
            M_SERVE: begin
                m_scnt++;
                if (m_scnt == SERVE) begin m_st = M_PLAY; m_scnt = 0; end
            end
            M_PLAY: begin
                cx = m_bx + m_dx * m_spd;
                cy = m_by + m_dy * m_spd;
                oy = m_by;
                if (cy <= 0) begin m_by = 0; m_dy = 1; end
                else if (cy >= YRES - BS) begin m_by = YRES - BS; m_dy = -1; end
                else m_by = cy;
                if (m_dx < 0 && cx <= PXL + PW && m_bx >= PXL + PW && overlap(oy, m_pl)) begin
                    m_bx = PXL + PW; m_dx = 1; bump();
                end else if (m_dx > 0 && cx + BS >= PXR && m_bx + BS <= PXR && overlap(oy, m_pr)) begin
                    m_bx = PXR - BS; m_dx = -1; bump();
                end else if (cx <= 0) begin
                    m_st = M_POINT; m_ptr = 1;
                end else if (cx >= XRES - BS) begin
                    m_st = M_POINT; m_ptr = 0;
                end else begin
                    m_bx = cx;
                end
            end
            M_POINT: begin
                if (m_ptr != 0) m_sr++; else m_sl++;
                m_spd = SPD0;
                if (m_sl == WIN || m_sr == WIN) begin
                    m_st = M_OVER;
                end else begin
                    m_bx = (XRES - BS) / 2; m_by = (YRES - BS) / 2;
                    m_dx = (m_ptr != 0) ? -1 : 1; m_dy = 1;
                    m_st = M_SERVE; m_scnt = 0;
                end
            end
            M_OVER: if (st) begin
                m_sl = 0; m_sr = 0; m_spd = SPD0;
                m_bx = (XRES - BS) / 2; m_by = (YRES - BS) / 2; m_dy = 1;
                m_st = M_SERVE; m_scnt = 0;
            end
            default: ;
        endcase
        m_pl = npl; m_pr = npr;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ball_x"}, int'(dut.ball_x_q), m_bx);
        check({tag, "_ball_y"}, int'(dut.ball_y_q), m_by);
        check({tag, "_pad_l"}, int'(dut.pad_l_q), m_pl);
        check({tag, "_pad_r"}, int'(dut.pad_r_q), m_pr);
        check({tag, "_scoreL"}, int'(io.scoreL), m_sl);
        check({tag, "_scoreR"}, int'(io.scoreR), m_sr);
    endtask

    // One frame in two clocks: the last visible pixel, then a random pixel that is rendered
    // while the tick is being applied (so it must show the pre-tick picture).
    task automatic do_tick(input bit st, input bit lu, input bit ld, input bit ru, input bit rd);
        int px, py;
        bit bl, hs, vs, exp_lit;
        io.nextX = 11'(XRES - 1); io.nextY = 10'(YRES - 1); io.blank_n = 1'b1;
        io.hSync_n = 1'($urandom_range(0, 1)); io.vSync_n = 1'($urandom_range(0, 1));
        io.start = st; io.lUp = lu; io.lDown = ld; io.rUp = ru; io.rDown = rd;
        @(negedge Clock);
        bl = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
            px = m_bx + int'($urandom_range(0, 10)) - 1;
            py = m_by + int'($urandom_range(0, 10)) - 1;
        end else begin
            px = int'($urandom_range(0, XRES - 1));
            py = int'($urandom_range(0, YRES - 1));
        end
        px = clampi(px, 0, XRES - 1);
        py = clampi(py, 0, YRES - 1);
        if (px == XRES - 1 && py == YRES - 1) px = XRES - 2;
        if (!bl) begin px = 0; py = 0; end
        hs = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
        io.nextX = 11'(px); io.nextY = 10'(py); io.blank_n = bl;
        io.hSync_n = hs; io.vSync_n = vs;
        exp_lit = bl && lit_at(px, py);
        model_tick(st, lu, ld, ru, rd);
        @(negedge Clock);
        check("tick_rgb", int'({io.red, io.green, io.blue}), exp_lit ? 32'hFFFFFF : 0);
        check("tick_blank", int'(io.blankOut_n), int'(bl));
        check("tick_hsync", int'(io.hSyncOut_n), int'(hs));
        check("tick_vsync", int'(io.vSyncOut_n), int'(vs));
        check_state("tick");
    endtask

    // Player behaviours: 0 random, 1 chase the ball, 2/3 run away from it.
    task automatic policy(input int mode, output bit lu, output bit ld, output bit ru, output bit rd);
        int bc;
        bc = m_by + BS / 2;
        if (mode == 0) begin
            lu = 1'($urandom_range(0, 1)); ld = 1'($urandom_range(0, 1));
            ru = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
        end else if (mode == 1) begin
            lu = (m_pl + PH / 2 > bc + 2); ld = (m_pl + PH / 2 < bc - 2);
            ru = (m_pr + PH / 2 > bc + 2); rd = (m_pr + PH / 2 < bc - 2);
        end else begin
            ld = (bc < YRES / 2); lu = !ld; rd = ld; ru = lu;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lu, ld, ru, rd;
        int mode, n;
        vecs[0]  = '{396, 296, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{403, 303, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{404, 300, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{395, 300, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{400, 295, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{400, 304, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16, 268, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{23, 331, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{24, 300, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16, 332, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{776, 268, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{783, 331, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{784, 300, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{396, 296, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{15, 267, 1'b1, 1'b0, 1'b0, 1'b0};

        io.nextX = 11'd100; io.nextY = 10'd50; io.blank_n = 1'b1;
        io.hSync_n = 1'b0; io.vSync_n = 1'b0;
        io.start = 1'b0; io.lUp = 1'b0; io.lDown = 1'b0; io.rUp = 1'b0; io.rDown = 1'b0;
        model_reset();
        #12;
        check("reset_rgb", int'({io.red, io.green, io.blue}), 0);
        check("reset_blank", int'(io.blankOut_n), 1);
        check("reset_hsync", int'(io.hSyncOut_n), 1);
        check("reset_vsync", int'(io.vSyncOut_n), 1);
        check("reset_ball_x", int'(dut.ball_x_q), 396);
        check("reset_ball_y", int'(dut.ball_y_q), 296);
        check("reset_pad_l", int'(dut.pad_l_q), 268);
        check("reset_pad_r", int'(dut.pad_r_q), 268);
        check("reset_scores", int'({io.scoreL, io.scoreR}), 0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Rendering table against the reset picture.
        foreach (vecs[i]) begin
            io.nextX = 11'(vecs[i].x); io.nextY = 10'(vecs[i].y); io.blank_n = vecs[i].bl;
            io.hSync_n = vecs[i].hs; io.vSync_n = vecs[i].vs;
            @(negedge Clock);
            check($sformatf("vec%0d_rgb", i), int'({io.red, io.green, io.blue}),
                  vecs[i].lit ? 32'hFFFFFF : 0);
            check($sformatf("vec%0d_blank", i), int'(io.blankOut_n), int'(vecs[i].bl));
            check($sformatf("vec%0d_hsync", i), int'(io.hSyncOut_n), int'(vecs[i].hs));
            check($sformatf("vec%0d_vsync", i), int'(io.vSyncOut_n), int'(vecs[i].vs));
        end

        // Idle ignores paddles; start begins the serve, which lasts SERVE ticks.
        do_tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SERVE; i++) do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("serve_hold_x", int'(dut.ball_x_q), 396);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("first_move_x", int'(dut.ball_x_q), 398);
        check("first_move_y", int'(dut.ball_y_q), 298);

        // Play a whole game with mixed player behaviours.
        n = 0; mode = 0;
        while (m_st != M_OVER && n < 15000) begin
            if (n % 150 == 0) mode = int'($urandom_range(0, 3));
            policy(mode, lu, ld, ru, rd);
            do_tick(1'($urandom_range(0, 1)), lu, ld, ru, rd);
            n++;
        end
        check("gameover_reached", int'(m_st == M_OVER), 1);
        check("winner_score", int'((io.scoreL > io.scoreR) ? io.scoreL : io.scoreR), WIN);
        // Game over freezes paddles until start, which clears the scores.
        do_tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_scores", int'({io.scoreL, io.scoreR}), 0);

        for (int i = 0; i < 400; i++) begin
            policy(int'($urandom_range(0, 1)), lu, ld, ru, rd);
            do_tick(1'($urandom_range(0, 1)), lu, ld, ru, rd);
        end

        // Asynchronous reset in the middle of a frame.
        io.nextX = 11'd300; io.nextY = 10'd200; io.blank_n = 1'b1;
        #3;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("midreset_rgb", int'({io.red, io.green, io.blue}), 0);
        check("midreset_hsync", int'(io.hSyncOut_n), 1);
        check_state("midreset");
        @(negedge Clock);
        Reset_n = 1'b1;
        do_tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        do_tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 80; i++) do_tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
